btb_assoc: RTL and testbench
============================

Name: btb_assoc

Overview:
- Parametrised set-associative branch target buffer with 2-bit direction counters; successor to the direct-lookup BTB in the fetch stage.
- Fetch presents PC each cycle and gets hit, taken-prediction and next-PC combinationally.
- EX stage writes resolved branch outcomes back; writes are gated by the pipeline enable (PCEN).
- Adds configurable ways/sets, LRU replacement, saturating counters, bulk flush and a hit statistics counter.

Parameters:
SETS, 16, number of sets; power of 2, >=2
WAYS, 2, associativity; power of 2, 1..8
CNT_W, 32, width of lookup-hit statistics counter

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-high reset
pc  input  32  fetch PC (word aligned)
btb_hit  output  1  valid tag match for pc in indexed set
pred_taken  output  1  btb_hit AND counter MSB set
pred_npc  output  32  predicted next PC: stored target if pred_taken, else pc+4
PCEN  input  1  pipeline advance enable; gates updates and statistics
upd_en  input  1  EX stage holds a resolved branch
upd_pc  input  32  PC of resolved branch (EX pc_add4 minus 4)
upd_taken  input  1  resolved direction
upd_target  input  32  resolved branch target
flush  input  1  invalidate all entries
hit_cnt  output  CNT_W  saturating count of accepted lookup hits

Behaviour:
- Address split: index = pc[IDX_W+1:2], IDX_W = log2(SETS); tag = pc[31:IDX_W+2]; pc[1:0] ignored. Same split for upd_pc.
- Entry per (set, way): valid, tag, target[31:0], ctr[1:0].
- Per set: one age field per way, log2(WAYS) bits, ages always a permutation of 0..WAYS-1.
- Lookup: purely combinational, zero latency.
  - At most one way matches; a match requires valid.
  - pred_npc = pc+4 on a miss.
- Update: occurs at a rising edge only when PCEN && upd_en && !flush.
  - Tag hit, taken: ctr saturating +1 (max 2'b11); target <= upd_target; touch way.
  - Tag hit, not-taken: ctr saturating -1 (min 2'b00); target unchanged; touch way.
  - Tag miss, taken: allocate. Victim = lowest-numbered invalid way; if none, the way with age WAYS-1. Write valid=1, tag, target, ctr=2'b10; touch way.
  - Tag miss, not-taken: no allocation, no state change.
- Touch: touched way age <= 0; every way in the set whose age was less than the touched way's old age increments; other ways are unchanged. Lookups do not touch.
- Lookup and update to the same set in one cycle: lookup sees pre-edge state; there is no write-through forwarding.
- flush: at the edge, clears all valid bits and restores ages to age[w]=w.
  - flush has priority over a simultaneous update; the update is dropped.
  - hit_cnt is not cleared by flush.
- hit_cnt: +1 at each edge with PCEN && btb_hit; saturates at all-ones.
- Reset (asynchronous, any time, including mid-update): all valid=0, age[w]=w, ctr=2'b00, target=0, tag=0, hit_cnt=0.
  - Outputs after reset: btb_hit=0, pred_taken=0, pred_npc=pc+4, hit_cnt=0.
- WAYS=1: age logic degenerates to constant; the victim is always way 0.

Decomposition:
- Package btb_pkg holds:
  - btb_ctr_t (2-bit) with constants STRONG_NT=2'b00, WEAK_NT=2'b01, WEAK_T=2'b10, STRONG_T=2'b11;
  - btb_entry_t struct {valid, tag, target, ctr};
  - saturating inc/dec functions.
- Tag width is derived locally from SETS.
- Sub-module btb_age_lru: one set's ages. Inputs: touch, touch_way, clear. Outputs: victim_way. Instantiated per set via generate.

Test Plan:
1. Assert RST mid-cycle after several updates -> immediately btb_hit=0, pred_npc=pc+4 for pc=0x40 (0x44), hit_cnt=0.
2. Update upd_pc=0x40, taken, target=0x100, PCEN=1 -> next cycle pc=0x40 gives btb_hit=1, pred_taken=1, pred_npc=0x100, ctr=WEAK_T.
3. Then two not-taken updates at 0x40 -> ctr=STRONG_NT, pred_taken=0, btb_hit=1, pred_npc=0x44. Then four taken updates -> ctr saturates at STRONG_T, no wrap.
4. SETS=16, WAYS=2: allocate 0x40 then 0x80 (both set 0), then a not-taken update at 0x40 (touch), then allocate 0xC0 -> 0x80 misses; 0x40 and 0xC0 hit.
5. Update with PCEN=0 -> no state change. Not-taken miss update -> no allocation, hit remains 0.
6. flush and a taken update in the same cycle -> all lookups miss afterwards. hit_cnt keeps its value and increments only on PCEN && hit cycles. Force hit_cnt to all-ones with CNT_W=4 -> stays at 4'hF.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types and helpers for the set-associative branch target buffer.
// Tags are stored zero-extended to the widest possible tag; the top uses only the low bits.
package btb_pkg;

   localparam int unsigned MAX_TAG_W = 29;

   typedef logic [1:0] btb_ctr_t;

   localparam btb_ctr_t STRONG_NT = 2'b00;
   localparam btb_ctr_t WEAK_NT   = 2'b01;
   localparam btb_ctr_t WEAK_T    = 2'b10;
   localparam btb_ctr_t STRONG_T  = 2'b11;

   typedef struct packed {
      logic                 valid;
      logic [MAX_TAG_W-1:0] tag;
      logic [31:0]          target;
      btb_ctr_t             ctr;
   } btb_entry_t;

   function automatic btb_ctr_t ctr_inc(btb_ctr_t c);
      return (c == STRONG_T) ? STRONG_T : c + 2'd1;
   endfunction

   function automatic btb_ctr_t ctr_dec(btb_ctr_t c);
      return (c == STRONG_NT) ? STRONG_NT : c - 2'd1;
   endfunction

endpackage

// File: rtl/btb_assoc_if.sv
// Fetch lookup and EX update bundle of the branch target buffer.
interface btb_assoc_if;
   logic [31:0] pc;
   logic        btb_hit;
   logic        pred_taken;
   logic [31:0] pred_npc;
   logic        PCEN;
   logic        upd_en;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        flush;

   modport master (
      output pc, PCEN, upd_en, upd_pc, upd_taken, upd_target, flush,
      input  btb_hit, pred_taken, pred_npc
   );

   modport slave (
      input  pc, PCEN, upd_en, upd_pc, upd_taken, upd_target, flush,
      output btb_hit, pred_taken, pred_npc
   );
endinterface

// File: rtl/btb_age_lru.sv
// Age-based true-LRU state for one set; ages are always a permutation of 0..WAYS-1.
module btb_age_lru #(
   parameter int unsigned WAYS  = 2,
   parameter int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             touch,
   input  logic [WAY_W-1:0] touch_way,
   input  logic             clear,
   output logic [WAY_W-1:0] victim_way
);

   logic [WAY_W-1:0] age_q [WAYS];
   logic [WAY_W-1:0] age_d [WAYS];
   logic [WAY_W-1:0] old_age;

   always_comb begin
      age_d   = age_q;
      old_age = age_q[touch_way];
      if (clear) begin
         for (int w = 0; w < WAYS; w++) age_d[w] = WAY_W'(w);
      end else if (touch) begin
         for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == touch_way) begin
               age_d[w] = '0;
            end else if (age_q[w] < old_age) begin
               age_d[w] = age_q[w] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      victim_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (age_q[w] == WAY_W'(WAYS - 1)) victim_way = WAY_W'(w);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int w = 0; w < WAYS; w++) age_q[w] <= WAY_W'(w);
      end else begin
         age_q <= age_d;
      end
   end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB: combinational lookup for fetch, PCEN-gated update from EX,
// LRU replacement, bulk flush and a saturating lookup-hit counter.
module btb_assoc
   import btb_pkg::*;
#(
   parameter int unsigned SETS  = 16,
   parameter int unsigned WAYS  = 2,
   parameter int unsigned CNT_W = 32
) (
   input  logic             CLK,
   input  logic             RST,
   btb_assoc_if.slave       bus,
   output logic [CNT_W-1:0] hit_cnt
);

   localparam int unsigned IDX_W = $clog2(SETS);
   localparam int unsigned TAG_W = 30 - IDX_W;
   localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   btb_entry_t entry_q [SETS][WAYS];
   btb_entry_t entry_d [SETS][WAYS];
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [IDX_W-1:0]     lk_idx, up_idx;
   logic [MAX_TAG_W-1:0] lk_tag, up_tag;
   logic                 lk_hit, up_hit;
   logic [WAY_W-1:0]     lk_way, up_way, inv_way, touch_way;
   logic                 inv_found, up_fire, touch;
   logic [WAY_W-1:0]     victim_way [SETS];
   logic                 unused_lo;

   assign unused_lo = ^{bus.pc[1:0], bus.upd_pc[1:0]};

   // Lookup reads only pre-edge state; no forwarding from a same-cycle update.
   always_comb begin
      lk_idx = bus.pc[IDX_W+1:2];
      lk_tag = '0;
      lk_tag[TAG_W-1:0] = bus.pc[31:IDX_W+2];
      lk_hit = 1'b0;
      lk_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (entry_q[lk_idx][w].valid && entry_q[lk_idx][w].tag == lk_tag) begin
            lk_hit = 1'b1;
            lk_way = WAY_W'(w);
         end
      end
      bus.btb_hit    = lk_hit;
      bus.pred_taken = lk_hit && entry_q[lk_idx][lk_way].ctr[1];
      bus.pred_npc   = bus.pred_taken ? entry_q[lk_idx][lk_way].target : bus.pc + 32'd4;
   end

   always_comb begin
      up_idx = bus.upd_pc[IDX_W+1:2];
      up_tag = '0;
      up_tag[TAG_W-1:0] = bus.upd_pc[31:IDX_W+2];
      up_hit    = 1'b0;
      up_way    = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (entry_q[up_idx][w].valid && entry_q[up_idx][w].tag == up_tag) begin
            up_hit = 1'b1;
            up_way = WAY_W'(w);
         end
         if (!entry_q[up_idx][w].valid) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
      end
      up_fire   = bus.PCEN && bus.upd_en && !bus.flush;
      touch     = up_fire && (up_hit || bus.upd_taken);
      touch_way = up_hit ? up_way : (inv_found ? inv_way : victim_way[up_idx]);
   end

   always_comb begin
      entry_d = entry_q;
      if (bus.flush) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) entry_d[s][w].valid = 1'b0;
         end
      end else if (touch) begin
         if (up_hit) begin
            if (bus.upd_taken) begin
               entry_d[up_idx][touch_way].ctr    = ctr_inc(entry_q[up_idx][touch_way].ctr);
               entry_d[up_idx][touch_way].target = bus.upd_target;
            end else begin
               entry_d[up_idx][touch_way].ctr = ctr_dec(entry_q[up_idx][touch_way].ctr);
            end
         end else begin
            entry_d[up_idx][touch_way].valid  = 1'b1;
            entry_d[up_idx][touch_way].tag    = up_tag;
            entry_d[up_idx][touch_way].target = bus.upd_target;
            entry_d[up_idx][touch_way].ctr    = WEAK_T;
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (bus.PCEN && lk_hit && cnt_q != '1) cnt_d = cnt_q + 1'b1;
   end

   assign hit_cnt = cnt_q;

   for (genvar s = 0; s < SETS; s++) begin : g_set
      btb_age_lru #(
         .WAYS  (WAYS),
         .WAY_W (WAY_W)
      ) u_lru (
         .CLK        (CLK),
         .RST        (RST),
         .touch      (touch && (up_idx == IDX_W'(s))),
         .touch_way  (touch_way),
         .clear      (bus.flush),
         .victim_way (victim_way[s])
      );
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) entry_q[s][w] <= '0;
         end
         cnt_q <= '0;
      end else begin
         entry_q <= entry_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_btb_assoc.sv
// Table-driven bench for btb_assoc (SETS=16, WAYS=2, CNT_W=4) with a scoreboard queue.
module tb_btb_assoc;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [3:0] hit_cnt;

   btb_assoc_if bus ();

   btb_assoc #(
      .SETS  (16),
      .WAYS  (2),
      .CNT_W (4)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .bus     (bus),
      .hit_cnt (hit_cnt)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] pc;
      logic        pcen;
      logic        upd_en;
      logic [31:0] upd_pc;
      logic        taken;
      logic [31:0] tgt;
      logic        flush;
      logic        hit;
      logic        ptk;
      logic [31:0] npc;
   } vec_t;

   typedef struct {
      int          row;
      logic        hit;
      logic        ptk;
      logic [31:0] npc;
      logic [3:0]  cnt;
   } exp_t;

   vec_t vq[$];
   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [31:0] pc, input logic pcen, input logic upd_en,
                      input logic [31:0] upd_pc, input logic taken, input logic [31:0] tgt,
                      input logic flush, input logic hit, input logic ptk,
                      input logic [31:0] npc);
      vec_t v;
      v.pc = pc; v.pcen = pcen; v.upd_en = upd_en; v.upd_pc = upd_pc; v.taken = taken;
      v.tgt = tgt; v.flush = flush; v.hit = hit; v.ptk = ptk; v.npc = npc;
      vq.push_back(v);
   endtask

   task automatic drive_idle();
      bus.PCEN = 1'b1; bus.upd_en = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0;
      bus.upd_target = '0; bus.flush = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] exp_cnt;
      exp_t       e;
      bus.pc = 32'h40;
      drive_idle();

      // Expected lookup is the state before each row's own edge.
      add(32'h40, 1, 1, 32'h40, 1, 32'h100, 0, 0, 0, 32'h44);
      add(32'h40, 1, 1, 32'h40, 0, 32'h0,   0, 1, 1, 32'h100);
      add(32'h40, 1, 1, 32'h40, 0, 32'h0,   0, 1, 0, 32'h44);
      add(32'h40, 1, 1, 32'h40, 0, 32'h0,   0, 1, 0, 32'h44);
      add(32'h40, 1, 1, 32'h40, 1, 32'h100, 0, 1, 0, 32'h44);
      add(32'h40, 1, 1, 32'h40, 1, 32'h100, 0, 1, 0, 32'h44);
      add(32'h40, 1, 1, 32'h40, 1, 32'h100, 0, 1, 1, 32'h100);
      add(32'h40, 1, 1, 32'h40, 1, 32'h104, 0, 1, 1, 32'h100);
      add(32'h40, 1, 1, 32'h40, 0, 32'h0,   0, 1, 1, 32'h104);
      add(32'h40, 1, 0, 32'h0,  0, 32'h0,   0, 1, 1, 32'h104);
      add(32'h40, 0, 1, 32'h40, 0, 32'h0,   0, 1, 1, 32'h104);
      add(32'h40, 0, 1, 32'h40, 0, 32'h0,   0, 1, 1, 32'h104);
      add(32'h80, 1, 1, 32'h80, 0, 32'h0,   0, 0, 0, 32'h84);
      add(32'h80, 1, 0, 32'h0,  0, 32'h0,   0, 0, 0, 32'h84);
      add(32'h80, 1, 1, 32'h80, 1, 32'h200, 0, 0, 0, 32'h84);
      add(32'h80, 1, 1, 32'h40, 0, 32'h0,   0, 1, 1, 32'h200);
      add(32'h40, 1, 1, 32'hC0, 1, 32'h300, 0, 1, 0, 32'h44);
      add(32'h80, 1, 0, 32'h0,  0, 32'h0,   0, 0, 0, 32'h84);
      add(32'hC0, 1, 0, 32'h0,  0, 32'h0,   0, 1, 1, 32'h300);
      add(32'h40, 1, 0, 32'h0,  0, 32'h0,   0, 1, 0, 32'h44);
      add(32'h48, 1, 1, 32'h48, 1, 32'h500, 0, 0, 0, 32'h4C);
      add(32'h48, 1, 0, 32'h0,  0, 32'h0,   0, 1, 1, 32'h500);
      add(32'h40, 1, 1, 32'h44, 1, 32'h600, 1, 1, 0, 32'h44);
      add(32'h40, 1, 0, 32'h0,  0, 32'h0,   0, 0, 0, 32'h44);
      add(32'h44, 1, 0, 32'h0,  0, 32'h0,   0, 0, 0, 32'h48);
      add(32'hC0, 1, 0, 32'h0,  0, 32'h0,   0, 0, 0, 32'hC4);
      add(32'h48, 1, 0, 32'h0,  0, 32'h0,   0, 0, 0, 32'h4C);
      add(32'h40, 1, 1, 32'h40, 1, 32'h700, 0, 0, 0, 32'h44);
      add(32'h40, 1, 0, 32'h0,  0, 32'h0,   0, 1, 1, 32'h700);
      add(32'h40, 1, 0, 32'h0,  0, 32'h0,   0, 1, 1, 32'h700);

      #1;
      chk("reset btb_hit", 32'(bus.btb_hit), 32'h0);
      chk("reset pred_npc", bus.pred_npc, 32'h44);
      chk("reset hit_cnt", 32'(hit_cnt), 32'h0);
      #11 RST = 1'b0;

      exp_cnt = '0;
      for (int i = 0; i < vq.size(); i++) begin
         @(posedge CLK);
         #1;
         bus.pc = vq[i].pc; bus.PCEN = vq[i].pcen; bus.upd_en = vq[i].upd_en;
         bus.upd_pc = vq[i].upd_pc; bus.upd_taken = vq[i].taken;
         bus.upd_target = vq[i].tgt; bus.flush = vq[i].flush;
         sb.push_back('{row: i, hit: vq[i].hit, ptk: vq[i].ptk, npc: vq[i].npc, cnt: exp_cnt});
         if (vq[i].pcen && vq[i].hit && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
         @(negedge CLK);
         if (sb.size() == 0) begin
            chk("scoreboard empty", 32'h1, 32'h0);
         end else begin
            e = sb.pop_front();
            chk($sformatf("row%0d btb_hit", e.row), 32'(bus.btb_hit), 32'(e.hit));
            chk($sformatf("row%0d pred_taken", e.row), 32'(bus.pred_taken), 32'(e.ptk));
            chk($sformatf("row%0d pred_npc", e.row), bus.pred_npc, e.npc);
            chk($sformatf("row%0d hit_cnt", e.row), 32'(hit_cnt), 32'(e.cnt));
         end
      end

      // Asynchronous reset mid-cycle while an update is pending.
      @(posedge CLK);
      #1;
      drive_idle();
      bus.pc = 32'h40; bus.upd_en = 1'b1; bus.upd_pc = 32'h40; bus.upd_taken = 1'b1;
      bus.upd_target = 32'h800;
      chk("pre-reset btb_hit", 32'(bus.btb_hit), 32'h1);
      chk("pre-reset hit_cnt", 32'(hit_cnt), 32'hF);
      #3 RST = 1'b1;
      #1;
      chk("async reset btb_hit", 32'(bus.btb_hit), 32'h0);
      chk("async reset pred_taken", 32'(bus.pred_taken), 32'h0);
      chk("async reset pred_npc", bus.pred_npc, 32'h44);
      chk("async reset hit_cnt", 32'(hit_cnt), 32'h0);
      @(posedge CLK);
      #1;
      chk("held reset btb_hit", 32'(bus.btb_hit), 32'h0);
      @(negedge CLK);
      RST = 1'b0;
      bus.upd_en = 1'b0;
      #1;
      chk("post-reset btb_hit", 32'(bus.btb_hit), 32'h0);
      chk("post-reset pred_npc", bus.pred_npc, 32'h44);
      chk("post-reset hit_cnt", 32'(hit_cnt), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
